// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned DEPTH_DEF      = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef logic [0:0] owner_t;

    localparam owner_t PORT_MEM = 1'b0;
    localparam owner_t PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_starve_arb.sv
// Two-requester arbiter: port 0 has priority, but port 1 is forced through
// after STARVE_MAX consecutive port-0 wins while it waited.
module rr_starve_arb
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          force_p1;

    assign force_p1 = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        gnt_c = 2'b00;
        if (req[PORT_MEM] && !(req[PORT_DBG] && force_p1)) begin
            gnt_c[PORT_MEM] = 1'b1;
        end else if (req[PORT_DBG]) begin
            gnt_c[PORT_DBG] = 1'b1;
        end
    end

    // Count port-0 wins over a waiting port 1; any other cycle clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (gnt_c[PORT_MEM] && req[PORT_DBG]) begin
            if (!force_p1) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the MEM stage (port 0) and the
// debug/loader port (port 1); routes 1-cycle read data back to the issuer.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            p0_req,
    input  logic            p0_we,
    input  logic [XLEN-1:0] p0_addr,
    input  logic [XLEN-1:0] p0_wdata,
    output logic            p0_gnt,
    output logic            p0_rvalid,
    output logic [XLEN-1:0] p0_rdata,
    input  logic            p1_req,
    input  logic            p1_we,
    input  logic [XLEN-1:0] p1_addr,
    input  logic [XLEN-1:0] p1_wdata,
    output logic            p1_gnt,
    output logic            p1_rvalid,
    output logic [XLEN-1:0] p1_rdata,
    output logic            stall,
    output logic            err,
    output logic            MemWrite,
    output logic            MemRead,
    output logic [XLEN-1:0] Addr,
    output logic [XLEN-1:0] Wdata,
    input  logic [XLEN-1:0] Rdata
);

    logic [1:0]      gnt_c;
    logic            any_gnt_c;
    logic            sel_we_c;
    logic            in_range_c;
    logic [XLEN-1:0] sel_addr_c;
    logic [XLEN-1:0] sel_wdata_c;

    owner_t          owner_q;
    logic            rd_pend_q;
    logic            rd_oor_q;
    logic            err_q;

    rr_starve_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({p1_req, p0_req}),
        .gnt_c (gnt_c)
    );

    // Steer the granted port onto the memory bus; idle bus is all zero.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        if (gnt_c[PORT_MEM]) begin
            sel_we_c    = p0_we;
            sel_addr_c  = p0_addr;
            sel_wdata_c = p0_wdata;
        end else if (gnt_c[PORT_DBG]) begin
            sel_we_c    = p1_we;
            sel_addr_c  = p1_addr;
            sel_wdata_c = p1_wdata;
        end
    end

    assign any_gnt_c  = |gnt_c;
    assign in_range_c = (sel_addr_c < XLEN'(DEPTH));

    assign p0_gnt   = gnt_c[PORT_MEM];
    assign p1_gnt   = gnt_c[PORT_DBG];
    assign stall    = p0_req && !gnt_c[PORT_MEM];
    assign MemWrite = any_gnt_c && sel_we_c && in_range_c;
    assign MemRead  = any_gnt_c && !sel_we_c && in_range_c;
    assign Addr     = sel_addr_c;
    assign Wdata    = sel_wdata_c;

    // Remember who owns the next-cycle read data and whether it is real.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= PORT_MEM;
            rd_pend_q <= 1'b0;
            rd_oor_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_pend_q <= any_gnt_c && !sel_we_c;
            if (any_gnt_c && !sel_we_c) begin
                owner_q  <= gnt_c[PORT_DBG] ? PORT_DBG : PORT_MEM;
                rd_oor_q <= !in_range_c;
            end
            if (any_gnt_c && !in_range_c) begin
                err_q <= 1'b1;
            end
        end
    end

    // Reset in the return cycle drops the pending read.
    assign p0_rvalid = rd_pend_q && (owner_q == PORT_MEM) && !reset;
    assign p1_rvalid = rd_pend_q && (owner_q == PORT_DBG) && !reset;
    assign p0_rdata  = (p0_rvalid && !rd_oor_q) ? Rdata : '0;
    assign p1_rdata  = (p1_rvalid && !rd_oor_q) ? Rdata : '0;
    assign err       = err_q;

endmodule
